op_unit_param: RTL and testbench
================================

Name: op_unit_param

Overview:
Parametrised successor to the fixed 28-bit suma/diferenta/produs/impartire blocks. It is a single signed arithmetic unit that runs one operation per request, selected by `op`: add, subtract, multiply or divide. Division is a multi-cycle restoring divider that also returns the remainder, and a ready/valid handshake stalls new requests while an operation is in flight. It sits between the calculator input decoder and the display/result formatter.

Parameters:
WIDTH, 28, operand/result width in bits (two's-complement signed); legal range 4..32
OPW, 2, opcode width (fixed encoding below; not meant to be overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
valid_in  input  1  request strobe; accepted only when ready=1
ready  output  1  unit idle, can accept a request this cycle
op  input  OPW  00 add, 01 subtract (n1-n2), 10 multiply, 11 divide (n1/n2)
n1  input  WIDTH  signed operand 1 / dividend
n2  input  WIDTH  signed operand 2 / divisor
valid_out  output  1  one-cycle pulse: d_out/rest/flags valid
d_out  output  WIDTH  signed result (quotient for divide)
rest  output  WIDTH  signed remainder (divide only, else 0)
ovrflow  output  1  true result not representable in WIDTH bits
err  output  1  divide by zero

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, ready=1, valid_out=0, d_out=0, rest=0, ovrflow=0, err=0. Any in-flight division is aborted; no valid_out is produced for it.
- Acceptance: a request is accepted at an edge where valid_in=1 and ready=1. op/n1/n2 are captured at that edge. valid_in while ready=0 is ignored (not queued).
- Output hold: d_out/rest/ovrflow/err are held until the next result; only valid_out pulses.
- FSM states: IDLE, DIV, DONE.
  - IDLE -> IDLE: add/sub/mul, or divide with n2=0. The result is registered at the accepting edge, so valid_out=1 during the following cycle (latency 1). ready stays 1, so back-to-back requests are accepted every cycle.
  - IDLE -> DIV: divide with n2!=0. ready=0, the operand magnitudes are loaded, and the bit counter is set to WIDTH.
  - DIV: one restoring step per cycle (shift partial remainder, trial subtract, set quotient bit). After WIDTH steps, go to DONE.
  - DONE: apply signs, register outputs, pulse valid_out, set ready=1, return to IDLE. Divide latency is WIDTH+1 cycles from the accepting edge to the valid_out cycle (29 for WIDTH=28).
- Add/sub: computed at WIDTH+1 bits. d_out is the low WIDTH bits (wrap). ovrflow=1 iff the WIDTH+1 result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. rest=0, err=0.
- Multiply: full 2*WIDTH-bit signed product. d_out is the low WIDTH bits. ovrflow=1 iff the upper WIDTH+1 bits of the product are not all equal. rest=0.
- Divide:
  - Truncates toward zero. The remainder takes the sign of the dividend, so n1 = d_out*n2 + rest.
  - n2=0: err=1, d_out=0, rest=0, ovrflow=0.
  - n1=MIN and n2=-1: d_out=MIN (wrapped), rest=0, ovrflow=1, err=0.
- Flags are valid only in the valid_out cycle and are held afterwards like data.
- Reset has priority over acceptance and over DONE completion in the same cycle.

Test Plan:
1. Reset, then add with n1=412, n2=3534 -> next cycle valid_out=1, d_out=3946, ovrflow=0; ready stays 1.
2. Add with n1=134217727, n2=1 (WIDTH=28) -> d_out=-134217728, ovrflow=1. Subtract with n1=-134217728, n2=1 -> d_out=134217727, ovrflow=1.
3. Multiply with n1=99999900, n2=120 -> ovrflow=1, d_out = low 28 bits of 11999988000 as signed. Multiply with n1=-5346, n2=13 -> d_out=-69498, ovrflow=0. Issue these back-to-back on consecutive cycles -> two consecutive valid_out pulses.
4. Divide 169/13 -> valid_out exactly 29 cycles after acceptance, d_out=13, rest=0. Divide 168/13 -> d_out=12, rest=12. Divide -168/13 -> d_out=-12, rest=-12. valid_in pulses while ready=0 are ignored, and no extra valid_out is produced.
5. Divide -2556/0 -> latency 1, err=1, d_out=0. Divide -134217728/-1 -> d_out=-134217728, ovrflow=1.
6. Start divide 168/13, assert rst 10 cycles later -> all outputs return to reset values, ready=1 the cycle after, and no valid_out pulse occurs.

Source files
------------

// File: rtl/op_unit_param.sv
// rtl/op_unit_param.sv - signed add/sub/mul/div unit with multi-cycle restoring divider
module op_unit_param #(
    parameter int WIDTH = 28,
    parameter int OPW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready,
    input  logic [OPW-1:0]          op,
    input  logic signed [WIDTH-1:0] n1,
    input  logic signed [WIDTH-1:0] n2,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] d_out,
    output logic signed [WIDTH-1:0] rest,
    output logic                    ovrflow,
    output logic                    err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL = OPW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [WIDTH-1:0]  rest_q, rest_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              vout_q, vout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic                      accept;
    logic signed [WIDTH:0]     add_res, sub_res;
    logic signed [2*WIDTH-1:0] n1_x, n2_x, prod;
    logic [WIDTH:0]            mul_hi;
    logic [WIDTH-1:0]          n1_mag, n2_mag;
    logic [WIDTH:0]            rem_sh, trial;
    logic                      qbit;
    logic [WIDTH-1:0]          rem_nx, quo_nx;

    assign ready     = (state_q != DIV);
    assign valid_out = vout_q;
    assign d_out     = dout_q;
    assign rest      = rest_q;
    assign ovrflow   = ovf_q;
    assign err       = err_q;

    assign accept  = valid_in && ready;
    assign add_res = {n1[WIDTH-1], n1} + {n2[WIDTH-1], n2};
    assign sub_res = {n1[WIDTH-1], n1} - {n2[WIDTH-1], n2};
    assign n1_x    = (2*WIDTH)'(n1);
    assign n2_x    = (2*WIDTH)'(n2);
    assign prod    = n1_x * n2_x;
    assign mul_hi  = prod[2*WIDTH-1:WIDTH-1];
    assign n1_mag  = n1[WIDTH-1] ? WIDTH'(-n1) : WIDTH'(n1);
    assign n2_mag  = n2[WIDTH-1] ? WIDTH'(-n2) : WIDTH'(n2);

    // One restoring step: the partial remainder stays below the divisor, so WIDTH bits hold it.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign qbit   = ~trial[WIDTH];
    assign rem_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        rest_d  = rest_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        vout_d  = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        case (state_q)
            DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dout_d  = qneg_q ? WIDTH'(-quo_nx) : quo_nx;
                    rest_d  = rneg_q ? WIDTH'(-rem_nx) : rem_nx;
                    // Only MIN / -1 yields a positive quotient with the top bit set.
                    ovf_d   = ~qneg_q & quo_nx[WIDTH-1];
                    err_d   = 1'b0;
                    vout_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    vout_d = 1'b1;
                    rest_d = '0;
                    err_d  = 1'b0;
                    if (op == OP_ADD) begin
                        dout_d = add_res[WIDTH-1:0];
                        ovf_d  = add_res[WIDTH] ^ add_res[WIDTH-1];
                    end else if (op == OP_SUB) begin
                        dout_d = sub_res[WIDTH-1:0];
                        ovf_d  = sub_res[WIDTH] ^ sub_res[WIDTH-1];
                    end else if (op == OP_MUL) begin
                        dout_d = prod[WIDTH-1:0];
                        ovf_d  = ~((&mul_hi) | ~(|mul_hi));
                    end else if (n2 == '0) begin
                        dout_d = '0;
                        ovf_d  = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        vout_d  = 1'b0;
                        state_d = DIV;
                        rem_d   = '0;
                        quo_d   = n1_mag;
                        dvs_d   = n2_mag;
                        cnt_d   = CW'(WIDTH);
                        qneg_d  = n1[WIDTH-1] ^ n2[WIDTH-1];
                        rneg_d  = n1[WIDTH-1];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            rest_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vout_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            rest_q  <= rest_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            vout_q  <= vout_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: tb/tb_op_unit_param.sv
// tb/tb_op_unit_param.sv - directed self-checking bench for op_unit_param
module tb_op_unit_param;

    localparam int W = 28;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic                ready;
    logic [1:0]          op;
    logic signed [W-1:0] n1, n2;
    logic                valid_out;
    logic signed [W-1:0] d_out, rest;
    logic                ovrflow, err;

    int n_checks = 0;
    int n_pass   = 0;

    op_unit_param #(.WIDTH(W), .OPW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready     (ready),
        .op        (op),
        .n1        (n1),
        .n2        (n2),
        .valid_out (valid_out),
        .d_out     (d_out),
        .rest      (rest),
        .ovrflow   (ovrflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input int a, input int b,
                          input int exp_lat, input int exp_d, input int exp_r,
                          input int exp_ovf, input int exp_err, input bit poke);
        int lat;
        @(negedge clk);
        op = o; n1 = W'(a); n2 = W'(b); valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (valid_out) break;
            if (poke && lat == 5) begin
                op = 2'b00; n1 = W'(1); n2 = W'(1); valid_in = 1'b1;
            end
            if (poke && lat == 7) valid_in = 1'b0;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dout"}, d_out, exp_d);
        chk({tag, "_rest"}, rest, exp_r);
        chk({tag, "_ovf"}, int'(ovrflow), exp_ovf);
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_ready"}, int'(ready), 1);
        @(negedge clk);
        chk({tag, "_vout_drop"}, int'(valid_out), 0);
        chk({tag, "_hold"}, d_out, exp_d);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; valid_in = 1'b0; op = '0; n1 = '0; n2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(ready), 1);
        chk("rst_vout", int'(valid_out), 0);
        chk("rst_dout", d_out, 0);
        chk("rst_rest", rest, 0);
        chk("rst_flags", int'({ovrflow, err}), 0);

        run_op("add", 2'b00, 412, 3534, 1, 3946, 0, 0, 0, 1'b0);
        run_op("add_ovf", 2'b00, 134217727, 1, 1, -134217728, 0, 1, 0, 1'b0);
        run_op("sub_ovf", 2'b01, -134217728, 1, 1, 134217727, 0, 1, 0, 1'b0);
        run_op("sub", 2'b01, 100, 250, 1, -150, 0, 0, 0, 1'b0);

        // Back-to-back multiplies on consecutive cycles
        @(negedge clk);
        op = 2'b10; n1 = W'(99999900); n2 = W'(120); valid_in = 1'b1;
        @(negedge clk);
        chk("mul1_vout", int'(valid_out), 1);
        chk("mul1_dout", d_out, -79607520);
        chk("mul1_ovf", int'(ovrflow), 1);
        chk("mul1_ready", int'(ready), 1);
        n1 = W'(-5346); n2 = W'(13);
        @(negedge clk);
        valid_in = 1'b0;
        chk("mul2_vout", int'(valid_out), 1);
        chk("mul2_dout", d_out, -69498);
        chk("mul2_ovf", int'(ovrflow), 0);
        @(negedge clk);
        chk("mul2_vout_drop", int'(valid_out), 0);

        run_op("div169", 2'b11, 169, 13, 29, 13, 0, 0, 0, 1'b1);
        run_op("div168", 2'b11, 168, 13, 29, 12, 12, 0, 0, 1'b0);
        run_op("divneg", 2'b11, -168, 13, 29, -12, -12, 0, 0, 1'b1);
        run_op("divnegd", 2'b11, 168, -13, 29, -12, 12, 0, 0, 1'b0);
        run_op("div0", 2'b11, -2556, 0, 1, 0, 0, 0, 1, 1'b0);
        run_op("divmin", 2'b11, -134217728, -1, 29, -134217728, 0, 1, 0, 1'b0);

        // Abort a division with reset
        @(negedge clk);
        op = 2'b11; n1 = W'(168); n2 = W'(13); valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy", int'(ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_dout", d_out, 0);
        chk("abort_rest", rest, 0);
        chk("abort_flags", int'({ovrflow, err}), 0);
        chk("abort_vout", int'(valid_out), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
